// File: rtl/sram_controller.sv
// Data-memory responder for the five-stage pipeline. Each 32-bit word access
// becomes two 16-bit accesses on an asynchronous SRAM, low half first.
// `ready` stays low while an access is in flight, which freezes the pipeline.

module sram_controller #(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int unsigned WAIT      = 2     // cycles per 16-bit access, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  localparam logic [3:0]  LastCnt = 4'(WAIT - 1);
  localparam logic [31:0] Base    = 32'(ADDR_BASE);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_write_q;
  logic [31:0] read_data_q;
  logic        req;
  logic [31:0] offset;
  logic [16:0] word_idx;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        unused_addr_bits;

  assign req    = rd_en | wr_en;

  // Address is used combinationally: the frozen pipeline holds it stable.
  // Subtraction wraps for below-base addresses; byte offset and upper bits drop.
  assign offset           = address - Base;
  assign word_idx         = offset[18:2];
  assign unused_addr_bits = ^{offset[31:19], offset[1:0]};

  // State and phase counter; reset returns to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; counter restarts at zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StLo;
      end
      StLo: begin
        if (cnt_q == LastCnt) state_d = StHi;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      StHi: begin
        if (cnt_q == LastCnt) state_d = StDone;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Latch the operation type on leaving idle; a simultaneous request is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_q <= 1'b0;
    end else if (state_q == StIdle && req) begin
      op_write_q <= wr_en;
    end
  end

  // Capture each read half on the last cycle of its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= 32'd0;
    end else if (!op_write_q && cnt_q == LastCnt) begin
      if (state_q == StLo) begin
        read_data_q[15:0] <= SRAM_DQ;
      end else if (state_q == StHi) begin
        read_data_q[31:16] <= SRAM_DQ;
      end
    end
  end

  assign read_data = read_data_q;

  // SRAM strobes, bus drive and handshake, decoded from the current state.
  always_comb begin
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    ready     = ~req;
    unique case (state_q)
      StIdle: begin
        ready = ~req;
      end
      StLo: begin
        SRAM_ADDR = {word_idx, 1'b0};
        SRAM_WE_N = ~op_write_q;
        dq_oe     = op_write_q;
        dq_out    = write_data[15:0];
        ready     = 1'b0;
      end
      StHi: begin
        SRAM_ADDR = {word_idx, 1'b1};
        SRAM_WE_N = ~op_write_q;
        dq_oe     = op_write_q;
        dq_out    = write_data[31:16];
        ready     = 1'b0;
      end
      StDone: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
    // The pipeline must not freeze while held in reset.
    if (rst) ready = 1'b1;
  end

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: word writes/reads through a halfword SRAM model,
// back-to-back loads, simultaneous request, mid-access reset, WAIT=1, idle.

module tb_sram_controller;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  logic        rd_en1, wr_en1;
  logic [31:0] address1, write_data1;
  logic [31:0] read_data1;
  logic        ready1;
  wire  [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        sram_we_n1;

  logic [15:0] mem  [0:1023];
  logic [15:0] mem1 [0:1023];
  logic        pre_en  = 1'b0;
  logic        pre_sel = 1'b0;
  logic [9:0]  pre_a   = '0;
  logic [15:0] pre_d   = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller u_dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n)
  );

  sram_controller #(.WAIT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en1),
    .wr_en      (wr_en1),
    .address    (address1),
    .write_data (write_data1),
    .read_data  (read_data1),
    .ready      (ready1),
    .SRAM_DQ    (sram_dq1),
    .SRAM_ADDR  (sram_addr1),
    .SRAM_WE_N  (sram_we_n1)
  );

  // Halfword SRAM models: drive the bus only during a pure load.
  assign sram_dq  = (rd_en && !wr_en && sram_we_n === 1'b1) ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign sram_dq1 = (rd_en1 && !wr_en1 && sram_we_n1 === 1'b1) ? mem1[sram_addr1[9:0]]
                                                                : 16'hzzzz;

  always @(posedge clk) begin
    if (sram_we_n === 1'b0) mem[sram_addr[9:0]] <= sram_dq;
    if (sram_we_n1 === 1'b0) mem1[sram_addr1[9:0]] <= sram_dq1;
    if (pre_en && !pre_sel) mem[pre_a] <= pre_d;
    if (pre_en && pre_sel) mem1[pre_a] <= pre_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic sel, input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_sel = sel;
    pre_a   = a;
    pre_d   = d;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // One access on the WAIT=2 instance. Pushes the expected read_data at DONE,
  // pops it when ready returns, and optionally checks the old word is held
  // until the last LO cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] load_val,
                           input bit chk_hold, output int start_cyc);
    logic [31:0] old_rd;
    logic [31:0] got;
    int          lowcnt;
    bit          done;
    @(negedge clk);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = data;
    old_rd     = exp_rd;
    if (!wr && rd) exp_rd = load_val;
    exp_q.push_back(exp_rd);
    lowcnt    = 0;
    done      = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      lowcnt++;
      if (chk_hold && i == W) check("hold_last_lo", read_data, old_rd);
      if (chk_hold && i == W + 1) check("low_half_update", read_data, {old_rd[31:16], exp_rd[15:0]});
      @(negedge clk);
    end
    if (!done) begin
      check("access_timeout", 32'd0, 32'd1);
    end else begin
      check("ready_low_cycles", 32'(lowcnt), 32'(2 * W + 1));
      got = exp_q.pop_front();
      check("done_read_data", read_data, got);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    int s1, s2, lowcnt;
    logic [17:0] a_lo, a_hi, a_done;
    logic [31:0] got;
    bit done;

    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'd0;
    rd_en1 = 1'b0; wr_en1 = 1'b0; address1 = 32'd1024; write_data1 = 32'd0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_hiz", 32'(sram_dq === 16'hzzzz), 32'd1);
    repeat (2) @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b0;

    // Write then read.
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0, s1);
    check("wr_lo_half", 32'(mem[2]), 32'h0000BEEF);
    check("wr_hi_half", 32'(mem[3]), 32'h0000DEAD);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0, s1);

    // Simultaneous request behaves as a write.
    do_access(1'b1, 1'b1, 32'd1040, 32'h12345678, 32'd0, 1'b0, s1);
    check("both_lo_half", 32'(mem[8]), 32'h00005678);
    check("both_hi_half", 32'(mem[9]), 32'h00001234);

    // Reset during the HI phase of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1060; write_data = 32'hAAAA5555;
    repeat (W + 1) @(negedge clk);
    #1;
    check("mid_we_n_low", 32'(sram_we_n), 32'd0);
    check("mid_hi_addr", 32'(sram_addr), 32'd19);
    #1;
    rst = 1'b1;
    #1;
    exp_rd = 32'd0;
    check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_read_data", read_data, 32'd0);
    check("mid_rst_lo_written", 32'(mem[18]), 32'h00005555);
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0, s1);

    // Back-to-back loads with preset contents, one idle cycle between.
    preset(1'b0, 10'd0, 16'h2222);
    preset(1'b0, 10'd1, 16'h1111);
    preset(1'b0, 10'd4, 16'h4444);
    preset(1'b0, 10'd5, 16'h3333);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h11112222, 1'b0, s1);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, 32'h33334444, 1'b1, s2);
    check("b2b_spacing", 32'(s2 - s1), 32'd7);

    // Idle: nothing moves for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_dq_hiz", 32'(sram_dq === 16'hzzzz), 32'd1);
      check("idle_read_data", read_data, exp_rd);
    end

    // WAIT=1 instance: load from 1024.
    preset(1'b1, 10'd0, 16'h5678);
    preset(1'b1, 10'd1, 16'h1234);
    @(negedge clk);
    rd_en1 = 1'b1;
    address1 = 32'd1024;
    exp_q.push_back(32'h12345678);
    lowcnt = 0;
    done = 1'b0;
    a_lo = '1; a_hi = '1; a_done = '1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 1) a_lo = sram_addr1;
      if (i == 2) a_hi = sram_addr1;
      if (ready1 === 1'b1) begin
        a_done = sram_addr1;
        done = 1'b1;
        break;
      end
      lowcnt++;
      @(negedge clk);
    end
    if (!done) begin
      check("w1_timeout", 32'd0, 32'd1);
    end else begin
      check("w1_ready_low", 32'(lowcnt), 32'd3);
      check("w1_addr_lo", 32'(a_lo), 32'd0);
      check("w1_addr_hi", 32'(a_hi), 32'd1);
      check("w1_addr_done", 32'(a_done), 32'd0);
      got = exp_q.pop_front();
      check("w1_read_data", read_data1, got);
    end
    rd_en1 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
